led_pwm_driver: RTL and testbench
=================================

Name: led_pwm_driver

Overview:
- Downstream consumer of the LED PIO output register in the anemometer SOPC.
- Takes the 8-bit LED pattern written by the Nios II, plus a brightness level and a blink enable from a second control PIO.
- Drives the board LEDs with frame-synchronous PWM dimming and optional slow blinking.
- Pattern, brightness and blink settings change only on PWM frame boundaries, so a software write never produces a truncated or glitched pulse.

Parameters:
- N_LEDS, 8: number of LED channels; width of led_pattern and led_out.
- PRESCALE, 50: clk cycles per PWM tick, minimum 1. With a 50 MHz clock this gives a 1 MHz tick.
- BLINK_FRAMES, 2048: PWM frames per blink half-period, minimum 1.

Ports:
- clk  in  1  system clock, single domain.
- reset_n  in  1  asynchronous, active-low reset.
- led_pattern  in  N_LEDS  per-LED enable, taken from the PIO data register output.
- brightness  in  4  global duty level, 0..15.
- blink_en  in  1  1 = blink all enabled LEDs.
- led_out  out  N_LEDS  registered LED drive, active-high.
- frame_start  out  1  one-cycle pulse when new settings take effect.

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on reset_n and clears every register immediately. Reset values:
  - led_out = 0, frame_start = 0
  - prescaler = 0, pwm_cnt = 0, blink_cnt = 0
  - shadow_pattern = 0, shadow_bright = 0, shadow_blink = 0
  - blink_phase = 1, so blinking starts in the on phase.
- Prescaler: counts 0..PRESCALE-1 and wraps to 0. tick = (prescaler == PRESCALE-1). With PRESCALE = 1, tick is asserted every cycle.
- PWM counter: 4-bit pwm_cnt increments on tick and wraps 15 -> 0. frame_end = tick && pwm_cnt == 15. One frame is 16*PRESCALE cycles.
- Settings update on frame_end, all in the same edge:
  - shadow_pattern <= led_pattern, shadow_bright <= brightness, shadow_blink <= blink_en.
  - blink_cnt increments. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- frame_start: asserted for exactly the cycle after frame_end, i.e. the first cycle of each new frame, with the new shadows valid.
- Inputs sampled only at frame_end. A change to led_pattern, brightness or blink_en mid-frame has no effect until the next frame. Inputs are synchronous to clk; no synchroniser is required.
- PWM duty:
  - pwm_on = 1 when shadow_bright == 15, otherwise (pwm_cnt < shadow_bright).
  - Level 0 is fully off. Level N (1..14) is on for ticks 0..N-1 of the frame. Level 15 is 100 % on.
- Output: led_out[i] <= shadow_pattern[i] & pwm_on & (~shadow_blink | blink_phase).
  - led_out is registered and lags the counter state by one cycle.
  - No combinational path from any input to led_out.
- Blink phase continues running while blink_en = 0, so re-enabling blinking does not restart the phase.
- Reset mid-frame: led_out drops to 0 asynchronously. After release, the first frame outputs 0 because shadows are 0, and settings load at the first frame_end.
- Simultaneous frame_end and blink wrap: both update in the same edge. The new blink_phase is used from the next cycle.

Test Plan (PRESCALE=2, BLINK_FRAMES=2, so 1 frame = 32 cycles):
- Reset: assert reset_n=0 mid-operation -> led_out=0 and frame_start=0 immediately. After release, led_out stays 0 for 32 cycles and frame_start pulses at cycle 32.
- Full on: led_pattern=0xA5, brightness=15, blink_en=0 -> from the cycle after the first frame_start, led_out=0xA5 continuously.
- Dimming: brightness=4, led_pattern=0xFF -> in each 32-cycle frame, led_out=0xFF for 8 cycles and 0x00 for 24 cycles. Rising edge falls 1 cycle after frame_start.
- Glitch-free update: write led_pattern 0x0F -> 0xF0 at cycle 10 of a frame with brightness=15 -> led_out holds 0x0F until the frame boundary, then becomes 0xF0.
- Blink: blink_en=1, brightness=15, pattern=0x81 -> led_out alternates between 0x81 for 2 frames (64 cycles) and 0x00 for 2 frames.
- Brightness 0 with blink: brightness=0, blink_en=1, pattern=0xFF -> led_out remains 0x00 in all phases.

Source files
------------

// File: rtl/led_pwm_if.sv
// led_pwm_if: LED pattern/settings bus from the control PIOs and the PWM drive outputs.
interface led_pwm_if #(
  parameter int N_LEDS = 8
);
  logic [N_LEDS-1:0] led_pattern;
  logic [3:0]        brightness;
  logic              blink_en;
  logic [N_LEDS-1:0] led_out;
  logic              frame_start;
  modport master (output led_pattern, brightness, blink_en, input led_out, frame_start);
  modport slave  (input led_pattern, brightness, blink_en, output led_out, frame_start);
endinterface

// File: rtl/led_pwm_driver.sv
// led_pwm_driver: frame-synchronous PWM dimming and slow blinking of the board LEDs.
module led_pwm_driver #(
  parameter int N_LEDS       = 8,
  parameter int PRESCALE     = 50,
  parameter int BLINK_FRAMES = 2048
) (
  input  logic     clk,
  input  logic     reset_n,
  led_pwm_if.slave bus
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  logic [PW-1:0]     prescaler;
  logic [3:0]        pwm_cnt;
  logic [BW-1:0]     blink_cnt;
  logic              blink_phase;
  logic [N_LEDS-1:0] shadow_pattern;
  logic [3:0]        shadow_bright;
  logic              shadow_blink;
  logic              tick, frame_end, blink_wrap, led_en;
  always_comb begin
    tick       = prescaler == PW'(PRESCALE - 1);
    frame_end  = tick && pwm_cnt == 4'd15;
    blink_wrap = blink_cnt == BW'(BLINK_FRAMES - 1);
    led_en     = (shadow_bright == 4'd15 || pwm_cnt < shadow_bright) && (!shadow_blink || blink_phase);
  end
  // Settings are only latched at frame_end so a mid-frame write never truncates a pulse.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      prescaler       <= '0;
      pwm_cnt         <= '0;
      blink_cnt       <= '0;
      blink_phase     <= 1'b1;
      shadow_pattern  <= '0;
      shadow_bright   <= '0;
      shadow_blink    <= 1'b0;
      bus.led_out     <= '0;
      bus.frame_start <= 1'b0;
    end else begin
      prescaler <= tick ? '0 : prescaler + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (frame_end) begin
        shadow_pattern <= bus.led_pattern;
        shadow_bright  <= bus.brightness;
        shadow_blink   <= bus.blink_en;
        blink_cnt      <= blink_wrap ? '0 : blink_cnt + 1'b1;
        if (blink_wrap) blink_phase <= ~blink_phase;
      end
      bus.frame_start <= frame_end;
      bus.led_out     <= shadow_pattern & {N_LEDS{led_en}};
    end
endmodule

// File: tb/tb_led_pwm_driver.sv
// tb_led_pwm_driver: table-driven, hand-sequenced and randomized checks against a cycle-count model.
module tb_led_pwm_driver;
  localparam int P  = 2;
  localparam int BF = 2;
  localparam int FL = 16 * P;

  typedef struct {
    logic [7:0] pat;
    logic [3:0] br;
    int         exp_on;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  led_pwm_if #(.N_LEDS(8)) bus ();
  led_pwm_driver #(.N_LEDS(8), .PRESCALE(P), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int tests = 0;
  int fails = 0;
  int n = 0;
  logic [7:0] cur_pat, nxt_pat;
  logic [3:0] cur_br, nxt_br;
  logic       cur_bl, nxt_bl;
  vec_t       vecs[5];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, n);
    end
  endtask

  task automatic model_reset();
    n = 0;
    cur_pat = '0; cur_br = '0; cur_bl = 1'b0;
    nxt_pat = '0; nxt_br = '0; nxt_bl = 1'b0;
  endtask

  // Model: n edges since reset release; frame f = n/FL, tick = (n%FL)/P,
  // blink phase flips every BF frames starting on; settings sampled in the last cycle of a frame.
  task automatic step();
    int f, t;
    logic ph;
    logic [7:0] e;
    f  = n / FL;
    t  = (n % FL) / P;
    ph = ((f / BF) % 2) == 0;
    e  = ((cur_br == 4'd15 || t < int'(cur_br)) && (!cur_bl || ph)) ? cur_pat : 8'h00;
    if (n % FL == FL - 1) begin
      nxt_pat = bus.led_pattern; nxt_br = bus.brightness; nxt_bl = bus.blink_en;
    end
    @(posedge clk);
    n++;
    if (n % FL == 0) begin
      cur_pat = nxt_pat; cur_br = nxt_br; cur_bl = nxt_bl;
    end
    #1;
    check("led_out", bus.led_out, e);
    check("frame_start", 8'(bus.frame_start), 8'(n % FL == 0));
  endtask

  task automatic to_boundary();
    do step(); while (n % FL != 0);
  endtask

  task automatic set_in(input logic [7:0] p, input logic [3:0] b, input logic bl);
    bus.led_pattern = p; bus.brightness = b; bus.blink_en = bl;
  endtask

  initial begin
    int on, off;
    vecs[0] = '{8'hA5, 4'd15, 32};
    vecs[1] = '{8'hFF, 4'd4,  8};
    vecs[2] = '{8'hFF, 4'd0,  0};
    vecs[3] = '{8'h3C, 4'd1,  2};
    vecs[4] = '{8'hFF, 4'd14, 28};
    set_in(8'h00, 4'd0, 1'b0);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset led_out", bus.led_out, 8'h00);
    check("reset frame_start", 8'(bus.frame_start), 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(vecs[i].pat, vecs[i].br, 1'b0);
      to_boundary();
      on = 0; off = 0;
      repeat (FL) begin
        step();
        if (bus.led_out === vecs[i].pat) on++;
        if (bus.led_out === 8'h00) off++;
      end
      check($sformatf("duty on %0d", i), 8'(on), 8'(vecs[i].exp_on));
      check($sformatf("duty total %0d", i), 8'(on + off), 8'(FL));
    end
    // Asynchronous reset while fully on, then a blank first frame.
    set_in(8'hA5, 4'd15, 1'b0);
    to_boundary();
    to_boundary();
    repeat (5) step();
    #2 reset_n = 1'b0;
    #1;
    check("async reset led_out", bus.led_out, 8'h00);
    check("async reset frame_start", 8'(bus.frame_start), 8'h00);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    on = 0;
    repeat (FL - 1) begin
      step();
      if (bus.led_out !== 8'h00) on++;
    end
    check("blank first frame", 8'(on), 8'h00);
    step();
    check("first frame_start", 8'(bus.frame_start), 8'h01);
    // Mid-frame pattern write only lands at the boundary.
    set_in(8'h0F, 4'd15, 1'b0);
    to_boundary();
    to_boundary();
    do step(); while (n % FL != 10);
    bus.led_pattern = 8'hF0;
    to_boundary();
    check("glitch hold", bus.led_out, 8'h0F);
    step();
    check("glitch update", bus.led_out, 8'hF0);
    // Blinking at full brightness, then blinking at brightness 0.
    set_in(8'h81, 4'd15, 1'b1);
    to_boundary();
    on = 0; off = 0;
    repeat (4 * FL) begin
      step();
      if (bus.led_out === 8'h81) on++;
      if (bus.led_out === 8'h00) off++;
    end
    check("blink on cycles", 8'(on), 8'(2 * FL));
    check("blink off cycles", 8'(off), 8'(2 * FL));
    set_in(8'hFF, 4'd0, 1'b1);
    to_boundary();
    on = 0;
    repeat (4 * FL) begin
      step();
      if (bus.led_out !== 8'h00) on++;
    end
    check("bright0 blink", 8'(on), 8'h00);
    for (int i = 0; i < 40; i++) begin
      set_in(8'($urandom), 4'($urandom), 1'($urandom));
      repeat ($urandom_range(1, 70)) step();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
